// File: rtl/wb_eth_core_arbiter.sv
// wb_eth_core_arbiter: two-master Wishbone arbiter for the shared system-bus slave.
// M0 (ethmac DMA) has priority. A fairness counter lets M1 (core) in after
// ETH_BURST_MAX back-to-back M0 grants while M1 waits.
// Optional macro WB_ARB_TIMEOUT_EN adds a slave-response watchdog that errors
// the owner after TIMEOUT unanswered strobe cycles.
module wb_eth_core_arbiter #(
   parameter int WB_DWIDTH     = 32,
   parameter int WB_SWIDTH     = 4,
   parameter int ETH_BURST_MAX = 4,
   parameter int TIMEOUT       = 255
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [31:0]          i_m0_wb_adr,
   input  logic [WB_SWIDTH-1:0] i_m0_wb_sel,
   input  logic                 i_m0_wb_we,
   input  logic [WB_DWIDTH-1:0] i_m0_wb_wdat,
   input  logic                 i_m0_wb_cyc,
   input  logic                 i_m0_wb_stb,
   output logic [WB_DWIDTH-1:0] o_m0_wb_rdat,
   output logic                 o_m0_wb_ack,
   output logic                 o_m0_wb_err,
   input  logic [31:0]          i_m1_wb_adr,
   input  logic [WB_SWIDTH-1:0] i_m1_wb_sel,
   input  logic                 i_m1_wb_we,
   input  logic [WB_DWIDTH-1:0] i_m1_wb_wdat,
   input  logic                 i_m1_wb_cyc,
   input  logic                 i_m1_wb_stb,
   output logic [WB_DWIDTH-1:0] o_m1_wb_rdat,
   output logic                 o_m1_wb_ack,
   output logic                 o_m1_wb_err,
   output logic [31:0]          o_s_wb_adr,
   output logic [WB_SWIDTH-1:0] o_s_wb_sel,
   output logic                 o_s_wb_we,
   output logic [WB_DWIDTH-1:0] o_s_wb_wdat,
   output logic                 o_s_wb_cyc,
   output logic                 o_s_wb_stb,
   input  logic [WB_DWIDTH-1:0] i_s_wb_rdat,
   input  logic                 i_s_wb_ack,
   input  logic                 i_s_wb_err,
   output logic [1:0]           o_grant
);

   typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} state_t;

   localparam logic [3:0] BURST_MAX = 4'(ETH_BURST_MAX);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       m0_req, m1_req;
   logic       to_fire;   // watchdog expires this cycle: err the owner
   logic       to_abort;  // watchdog expired earlier: slave side held idle

   assign m0_req = i_m0_wb_cyc & i_m0_wb_stb;
   assign m1_req = i_m1_wb_cyc & i_m1_wb_stb;

   // Next owner and fairness count; grant is held until the owner drops cyc.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (m0_req && !(m1_req && cnt_q == BURST_MAX)) begin
               state_d = OWN_M0;
               if (!m1_req)
                  cnt_d = 4'd0;
               else if (cnt_q != BURST_MAX)
                  cnt_d = cnt_q + 4'd1;
            end else if (m1_req) begin
               state_d = OWN_M1;
               cnt_d   = 4'd0;
            end
         end
         OWN_M0: if (!i_m0_wb_cyc) state_d = IDLE;
         OWN_M1: if (!i_m1_wb_cyc) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Owner state and fairness count registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wait_cnt_q, wait_cnt_d;
   logic          abort_q, abort_d;
   logic          owner_stb;

   // Watchdog: count unanswered owner strobes, fire on the TIMEOUT-th one.
   always_comb begin
      owner_stb = ((state_q == OWN_M0) && i_m0_wb_cyc && i_m0_wb_stb) ||
                  ((state_q == OWN_M1) && i_m1_wb_cyc && i_m1_wb_stb);
      to_fire   = owner_stb && !abort_q && !i_s_wb_ack && !i_s_wb_err &&
                  (wait_cnt_q == TW'(TIMEOUT - 1));
      wait_cnt_d = wait_cnt_q;
      abort_d    = abort_q;
      if (state_q == IDLE || i_s_wb_ack || i_s_wb_err || abort_q || to_fire)
         wait_cnt_d = '0;
      else if (owner_stb)
         wait_cnt_d = wait_cnt_q + TW'(1);
      if (state_d == IDLE)
         abort_d = 1'b0;
      else if (to_fire)
         abort_d = 1'b1;
   end

   // Watchdog registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wait_cnt_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         abort_q    <= abort_d;
      end
   end

   assign to_abort = abort_q;
`else
   // No watchdog in this build; TIMEOUT has no effect.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign to_fire  = 1'b0;
   assign to_abort = 1'b0;
`endif

   assign o_m0_wb_rdat = i_s_wb_rdat;
   assign o_m1_wb_rdat = i_s_wb_rdat;
   assign o_grant      = {state_q == OWN_M1, state_q == OWN_M0};

   // Request mux to the slave and response demux back to the owner only.
   always_comb begin
      o_s_wb_adr  = 32'd0;
      o_s_wb_sel  = '0;
      o_s_wb_we   = 1'b0;
      o_s_wb_wdat = '0;
      o_s_wb_cyc  = 1'b0;
      o_s_wb_stb  = 1'b0;
      o_m0_wb_ack = 1'b0;
      o_m0_wb_err = 1'b0;
      o_m1_wb_ack = 1'b0;
      o_m1_wb_err = 1'b0;
      case (state_q)
         OWN_M0: begin
            o_s_wb_adr  = i_m0_wb_adr;
            o_s_wb_sel  = i_m0_wb_sel;
            o_s_wb_we   = i_m0_wb_we;
            o_s_wb_wdat = i_m0_wb_wdat;
            o_s_wb_cyc  = i_m0_wb_cyc & ~to_abort;
            o_s_wb_stb  = i_m0_wb_stb & ~to_abort;
            // Gating with cyc drops a late ack after the master abandons the cycle.
            o_m0_wb_ack = i_m0_wb_cyc & i_s_wb_ack & ~to_abort;
            o_m0_wb_err = (i_m0_wb_cyc & i_s_wb_err & ~to_abort) | to_fire;
         end
         OWN_M1: begin
            o_s_wb_adr  = i_m1_wb_adr;
            o_s_wb_sel  = i_m1_wb_sel;
            o_s_wb_we   = i_m1_wb_we;
            o_s_wb_wdat = i_m1_wb_wdat;
            o_s_wb_cyc  = i_m1_wb_cyc & ~to_abort;
            o_s_wb_stb  = i_m1_wb_stb & ~to_abort;
            o_m1_wb_ack = i_m1_wb_cyc & i_s_wb_ack & ~to_abort;
            o_m1_wb_err = (i_m1_wb_cyc & i_s_wb_err & ~to_abort) | to_fire;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_eth_core_arbiter.sv
// Directed bench for wb_eth_core_arbiter (ETH_BURST_MAX=4, TIMEOUT=8).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
module tb_wb_eth_core_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] m0_adr = '0, m1_adr = '0;
   logic [3:0]  m0_sel = '0, m1_sel = '0;
   logic        m0_we = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_wdat = '0, m1_wdat = '0;
   logic        m0_cyc = 1'b0, m0_stb = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
   logic [31:0] m0_rdat, m1_rdat;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] s_adr, s_wdat;
   logic [3:0]  s_sel;
   logic        s_we, s_cyc, s_stb;
   logic [31:0] s_rdat = '0;
   logic        s_ack = 1'b0, s_err = 1'b0;
   logic [1:0]  grant;

   int nvec = 0;
   int nerr = 0;

   wb_eth_core_arbiter #(
      .WB_DWIDTH(32), .WB_SWIDTH(4), .ETH_BURST_MAX(4), .TIMEOUT(8)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m0_wb_adr(m0_adr), .i_m0_wb_sel(m0_sel), .i_m0_wb_we(m0_we),
      .i_m0_wb_wdat(m0_wdat), .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb),
      .o_m0_wb_rdat(m0_rdat), .o_m0_wb_ack(m0_ack), .o_m0_wb_err(m0_err),
      .i_m1_wb_adr(m1_adr), .i_m1_wb_sel(m1_sel), .i_m1_wb_we(m1_we),
      .i_m1_wb_wdat(m1_wdat), .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb),
      .o_m1_wb_rdat(m1_rdat), .o_m1_wb_ack(m1_ack), .o_m1_wb_err(m1_err),
      .o_s_wb_adr(s_adr), .o_s_wb_sel(s_sel), .o_s_wb_we(s_we),
      .o_s_wb_wdat(s_wdat), .o_s_wb_cyc(s_cyc), .o_s_wb_stb(s_stb),
      .i_s_wb_rdat(s_rdat), .i_s_wb_ack(s_ack), .i_s_wb_err(s_err),
      .o_grant(grant)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m0(input logic v);
      m0_cyc = v;
      m0_stb = v;
   endtask

   task automatic set_m1(input logic v);
      m1_cyc = v;
      m1_stb = v;
   endtask

   // Single beat for the current owner (called just after the grant edge):
   // ack one cycle, owner drops, one IDLE cycle; optionally re-request then.
   task automatic serve(input int owner, input logic rearm);
      s_ack = 1'b1;
      #1;
      if (owner == 0) check_vec("serve_m0_ack", {63'd0, m0_ack}, 64'd1);
      else            check_vec("serve_m1_ack", {63'd0, m1_ack}, 64'd1);
      tick();
      s_ack = 1'b0;
      if (owner == 0) set_m0(1'b0); else set_m1(1'b0);
      tick();
      #1;
      check_vec("serve_idle_grant", {62'd0, grant}, 64'd0);
      if (rearm) begin
         if (owner == 0) set_m0(1'b1); else set_m1(1'b1);
      end
   endtask

   initial begin : stim
      logic [1:0] exp_g [5];
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
      exp_g[3] = 2'b01; exp_g[4] = 2'b10;

      // Reset with both masters requesting.
      set_m0(1'b1);
      set_m1(1'b1);
      s_ack = 1'b1;
      tick();
      tick();
      #1;
      $display("reset: grant=%b s_cyc=%b", grant, s_cyc);
      check_vec("rst_grant", {62'd0, grant}, 64'd0);
      check_vec("rst_s_cyc", {63'd0, s_cyc}, 64'd0);
      check_vec("rst_s_stb", {63'd0, s_stb}, 64'd0);
      check_vec("rst_m0_ack", {63'd0, m0_ack}, 64'd0);
      set_m0(1'b0);
      set_m1(1'b0);
      s_ack = 1'b0;
      rst_n = 1'b1;
      tick();

      // M1-only read at 0x100.
      m1_adr = 32'h100;
      m1_we  = 1'b0;
      set_m1(1'b1);
      #1;
      check_vec("m1_pre_grant", {62'd0, grant}, 64'd0);
      tick();
      #1;
      check_vec("m1_grant", {62'd0, grant}, 64'd2);
      check_vec("m1_s_adr", {32'd0, s_adr}, 64'h100);
      check_vec("m1_s_cyc", {63'd0, s_cyc}, 64'd1);
      tick();
      s_ack  = 1'b1;
      s_rdat = 32'hCAFE_F00D;
      #1;
      $display("m1 read: grant=%b m1_ack=%b rdat=%h", grant, m1_ack, m1_rdat);
      check_vec("m1_ack", {63'd0, m1_ack}, 64'd1);
      check_vec("m1_m0_ack", {63'd0, m0_ack}, 64'd0);
      check_vec("m1_rdat", {32'd0, m1_rdat}, 64'hCAFE_F00D);
      tick();
      s_ack = 1'b0;
      set_m1(1'b0);
      #1;
      check_vec("m1_ack_done", {63'd0, m1_ack}, 64'd0);
      tick();
      #1;
      check_vec("m1_idle", {62'd0, grant}, 64'd0);

      // Fairness: four M0 grants then M1, both requesting throughout.
      set_m0(1'b1);
      set_m1(1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         $display("fair grant %0d: grant=%b", i, grant);
         check_vec($sformatf("fair_grant%0d", i), {62'd0, grant}, {62'd0, exp_g[i]});
         serve((i < 4) ? 0 : 1, (i < 4));
      end
      // Count was cleared by the M1 grant: simultaneous request goes to M0.
      set_m1(1'b1);
      tick();
      #1;
      check_vec("fair_after_clear", {62'd0, grant}, 64'd1);
      serve(0, 1'b0);
      set_m1(1'b0);
      tick();
      tick();

      // M0 4-beat locked burst, M1 arrives at beat 2.
      set_m0(1'b1);
      tick();
      for (int b = 0; b < 4; b++) begin
         s_ack = 1'b1;
         if (b == 1) set_m1(1'b1);
         #1;
         $display("burst beat %0d: grant=%b m0_ack=%b m1_ack=%b", b, grant, m0_ack, m1_ack);
         check_vec($sformatf("burst_grant%0d", b), {62'd0, grant}, 64'd1);
         check_vec($sformatf("burst_m0_ack%0d", b), {63'd0, m0_ack}, 64'd1);
         check_vec($sformatf("burst_m1_ack%0d", b), {63'd0, m1_ack}, 64'd0);
         tick();
      end
      s_ack = 1'b0;
      set_m0(1'b0);
      #1;
      check_vec("burst_drop_grant", {62'd0, grant}, 64'd1);
      check_vec("burst_drop_s_cyc", {63'd0, s_cyc}, 64'd0);
      tick();
      #1;
      check_vec("burst_idle_gap", {62'd0, grant}, 64'd0);
      tick();
      #1;
      check_vec("burst_then_m1", {62'd0, grant}, 64'd2);
      set_m1(1'b0);
      tick();
      tick();

      // Owner abandons the cycle; slave ack arrives afterwards.
      set_m1(1'b1);
      tick();
      #1;
      check_vec("abandon_grant", {62'd0, grant}, 64'd2);
      tick();
      set_m1(1'b0);
      s_ack = 1'b1;
      #1;
      check_vec("abandon_ack_same", {63'd0, m1_ack}, 64'd0);
      tick();
      #1;
      $display("abandon: grant=%b m0_ack=%b m1_ack=%b", grant, m0_ack, m1_ack);
      check_vec("abandon_m1_ack", {63'd0, m1_ack}, 64'd0);
      check_vec("abandon_m0_ack", {63'd0, m0_ack}, 64'd0);
      check_vec("abandon_idle", {62'd0, grant}, 64'd0);
      s_ack = 1'b0;
      tick();

      // Non-responding slave.
      set_m1(1'b1);
      tick();
      for (int k = 1; k <= 12; k++) begin
         #1;
`ifdef WB_ARB_TIMEOUT_EN
         check_vec($sformatf("to_err%0d", k), {63'd0, m1_err}, {63'd0, k == 8});
         check_vec($sformatf("to_stb%0d", k), {63'd0, s_stb}, {63'd0, k <= 8});
`else
         check_vec($sformatf("to_err%0d", k), {63'd0, m1_err}, 64'd0);
         check_vec($sformatf("to_stb%0d", k), {63'd0, s_stb}, 64'd1);
`endif
         check_vec($sformatf("to_m0_err%0d", k), {63'd0, m0_err}, 64'd0);
         check_vec($sformatf("to_grant%0d", k), {62'd0, grant}, 64'd2);
         tick();
      end
      set_m1(1'b0);
      tick();
      #1;
      check_vec("to_release", {62'd0, grant}, 64'd0);

      // Reset asserted in the middle of an acked M0 cycle.
      set_m0(1'b1);
      tick();
      s_ack = 1'b1;
      #1;
      check_vec("mid_rst_pre_ack", {63'd0, m0_ack}, 64'd1);
      rst_n = 1'b0;
      #1;
      $display("mid reset: grant=%b m0_ack=%b s_cyc=%b", grant, m0_ack, s_cyc);
      check_vec("mid_rst_ack", {63'd0, m0_ack}, 64'd0);
      check_vec("mid_rst_grant", {62'd0, grant}, 64'd0);
      check_vec("mid_rst_s_cyc", {63'd0, s_cyc}, 64'd0);
      s_ack = 1'b0;
      set_m0(1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
